// File: rtl/line_buffer_ctrl.sv
// 3x3 sliding-window controller over two external single-port-read line buffers.
// One pixel per cycle; windows are masked until two full rows and columns are present.
module line_buffer_ctrl #(
   parameter int D_WIDTH            = 16,
   parameter int LINE_BUF_ADDR_BITS = 5,
   parameter int IMG_W              = 30,
   parameter int IMG_H              = 30
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [D_WIDTH-1:0]            in_data,
   output logic                          in_ready,
   output logic [LINE_BUF_ADDR_BITS-1:0] lb_rd_addr,
   input  logic [D_WIDTH-1:0]            lb_rd_data_I,
   input  logic [D_WIDTH-1:0]            lb_rd_data_II,
   output logic [LINE_BUF_ADDR_BITS-1:0] lb_wr_addr,
   output logic                          lb_wr_en_I,
   output logic                          lb_wr_en_II,
   output logic [D_WIDTH-1:0]            lb_wr_data_I,
   output logic [D_WIDTH-1:0]            lb_wr_data_II,
   output logic                          win_valid,
   input  logic                          win_ready,
   output logic [9*D_WIDTH-1:0]          win_data,
   output logic                          frame_done
);

   localparam int ROW_BITS = (IMG_H > 2) ? $clog2(IMG_H) : 2;

   localparam logic [LINE_BUF_ADDR_BITS-1:0] COL_LAST = LINE_BUF_ADDR_BITS'(IMG_W - 1);
   localparam logic [LINE_BUF_ADDR_BITS-1:0] COL_TWO  = LINE_BUF_ADDR_BITS'(2);
   localparam logic [LINE_BUF_ADDR_BITS-1:0] COL_ONE  = LINE_BUF_ADDR_BITS'(1);
   localparam logic [ROW_BITS-1:0]           ROW_LAST = ROW_BITS'(IMG_H - 1);
   localparam logic [ROW_BITS-1:0]           ROW_TWO  = ROW_BITS'(2);
   localparam logic [ROW_BITS-1:0]           ROW_ONE  = ROW_BITS'(1);

   logic [LINE_BUF_ADDR_BITS-1:0] col_reg, col_next;
   logic [ROW_BITS-1:0]           row_reg, row_next;

   logic                          s1_valid_reg;
   logic [D_WIDTH-1:0]            s1_data_reg;
   logic [LINE_BUF_ADDR_BITS-1:0] s1_col_reg;
   logic [ROW_BITS-1:0]           s1_row_reg;

   logic win_valid_reg;
   logic frame_done_reg;

   logic stall;
   logic accept;
   logic advance;
   logic s1_is_last;
   logic s1_makes_window;

   logic [D_WIDTH-1:0] new_col [3];

   // Outputs that must read low during reset are gated so they drop in the same cycle.
   assign win_valid  = win_valid_reg & ~rst;
   assign frame_done = frame_done_reg & ~rst;

   assign stall   = win_valid & ~win_ready;
   assign in_ready = ~stall & ~rst;
   assign accept  = in_valid & in_ready;
   assign advance = s1_valid_reg & ~stall & ~rst;

   assign s1_is_last      = (s1_col_reg == COL_LAST) && (s1_row_reg == ROW_LAST);
   assign s1_makes_window = (s1_col_reg >= COL_TWO) && (s1_row_reg >= ROW_TWO);

   always_comb begin
      col_next = col_reg;
      row_next = row_reg;
      if (col_reg == COL_LAST) begin
         col_next = '0;
         row_next = (row_reg == ROW_LAST) ? '0 : row_reg + ROW_ONE;
      end else begin
         col_next = col_reg + COL_ONE;
      end
   end

   // While S1 is held the read is re-issued at its own column so the data is re-presented.
   assign lb_rd_addr = (s1_valid_reg && stall) ? s1_col_reg : col_reg;

   assign lb_wr_addr    = s1_col_reg;
   assign lb_wr_en_I    = advance;
   assign lb_wr_en_II   = advance;
   assign lb_wr_data_I  = advance ? s1_data_reg : '0;
   assign lb_wr_data_II = advance ? lb_rd_data_I : '0;

   assign new_col[0] = lb_rd_data_II;
   assign new_col[1] = lb_rd_data_I;
   assign new_col[2] = s1_data_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         col_reg        <= '0;
         row_reg        <= '0;
         s1_valid_reg   <= 1'b0;
         s1_data_reg    <= '0;
         s1_col_reg     <= '0;
         s1_row_reg     <= '0;
         win_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         if (accept) begin
            col_reg      <= col_next;
            row_reg      <= row_next;
            s1_valid_reg <= 1'b1;
            s1_data_reg  <= in_data;
            s1_col_reg   <= col_reg;
            s1_row_reg   <= row_reg;
         end else if (advance) begin
            s1_valid_reg <= 1'b0;
         end

         if (advance) begin
            win_valid_reg <= s1_makes_window;
         end else if (win_ready) begin
            win_valid_reg <= 1'b0;
         end

         frame_done_reg <= advance && s1_is_last;
      end
   end

   // Each window row is a 3-tap shift register fed by its own line source.
   genvar gi, gj;
   generate
      for (gi = 0; gi < 3; gi++) begin : gen_row
         logic [D_WIDTH-1:0] tap_reg [3];

         always_ff @(posedge clk) begin
            if (rst) begin
               tap_reg[0] <= '0;
               tap_reg[1] <= '0;
               tap_reg[2] <= '0;
            end else if (advance) begin
               tap_reg[0] <= tap_reg[1];
               tap_reg[1] <= tap_reg[2];
               tap_reg[2] <= new_col[gi];
            end
         end

         for (gj = 0; gj < 3; gj++) begin : gen_tap
            assign win_data[(3*gi+gj)*D_WIDTH +: D_WIDTH] = tap_reg[gj];
         end
      end
   endgenerate

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: external line buffers modelled as registered-read arrays,
// frame-level reference model of windows and writes, plus literal expectations.
module tb_line_buffer_ctrl;

   localparam int DW = 16;
   localparam int AB = 5;
   localparam int W  = 30;
   localparam int H  = 30;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [DW-1:0]     in_data = '0;
   logic              in_ready;
   logic [AB-1:0]     lb_rd_addr;
   logic [DW-1:0]     lb_rd_data_I = '0;
   logic [DW-1:0]     lb_rd_data_II = '0;
   logic [AB-1:0]     lb_wr_addr;
   logic              lb_wr_en_I, lb_wr_en_II;
   logic [DW-1:0]     lb_wr_data_I, lb_wr_data_II;
   logic              win_valid;
   logic              win_ready = 1'b1;
   logic [9*DW-1:0]   win_data;
   logic              frame_done;

   line_buffer_ctrl #(.D_WIDTH(DW), .LINE_BUF_ADDR_BITS(AB), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .lb_rd_addr(lb_rd_addr), .lb_rd_data_I(lb_rd_data_I), .lb_rd_data_II(lb_rd_data_II),
      .lb_wr_addr(lb_wr_addr), .lb_wr_en_I(lb_wr_en_I), .lb_wr_en_II(lb_wr_en_II),
      .lb_wr_data_I(lb_wr_data_I), .lb_wr_data_II(lb_wr_data_II),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // External line buffers, 1-cycle synchronous read, garbage initial contents.
   logic [DW-1:0] mem_i  [1<<AB];
   logic [DW-1:0] mem_ii [1<<AB];
   initial begin
      for (int i = 0; i < (1<<AB); i++) begin
         mem_i[i]  = DW'(16'hBAD0 + i);
         mem_ii[i] = DW'(16'hCAF0 + i);
      end
   end
   always @(posedge clk) begin
      if (lb_wr_en_I)  mem_i[lb_wr_addr]  <= lb_wr_data_I;
      if (lb_wr_en_II) mem_ii[lb_wr_addr] <= lb_wr_data_II;
      lb_rd_data_I  <= mem_i[lb_rd_addr];
      lb_rd_data_II <= mem_ii[lb_rd_addr];
   end

   bit bp_en = 1'b0;
   always @(posedge clk) begin
      #1;
      win_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [9*DW-1:0] data;
      bit              last;
      int              cyc;
   } win_t;
   typedef struct {
      int            r;
      int            c;
      logic [DW-1:0] v;
   } wr_t;

   win_t          exp_q[$];
   wr_t           wr_q[$];
   logic [DW-1:0] img [H][W];
   int            mr = 0, mc = 0;
   int            cyc = 0;

   int              win_cnt = 0, done_cnt = 0, done_at = 0;
   bit              lat_en = 1'b0;
   logic [9*DW-1:0] first_win = '0, frame2_win = '0, last_win = '0;
   logic [9*DW-1:0] prev_win_data = '0;
   bit              prev_stall = 1'b0, prev_done = 1'b0;
   bit              cap_seen = 1'b0;
   logic [AB-1:0]   cap_addr = '0;
   logic [DW-1:0]   cap_d1 = '0, cap_d2 = '0;

   always @(negedge clk) begin
      win_t e;
      wr_t  w;
      cyc++;
      chk("in_ready_rule", 144'(in_ready), 144'(!(win_valid && !win_ready) && !rst));
      chk("wr_en_pair", 144'(lb_wr_en_I), 144'(lb_wr_en_II));
      if (prev_stall && !rst) chk("win_data_stable", win_data, prev_win_data);
      if (rst) begin
         chk("rst_win_valid", 144'(win_valid), 144'(0));
         chk("rst_frame_done", 144'(frame_done), 144'(0));
         chk("rst_wr_en", 144'(lb_wr_en_I), 144'(0));
         exp_q.delete();
         wr_q.delete();
         mr = 0;
         mc = 0;
      end else begin
         if (frame_done) begin
            done_cnt++;
            done_at = win_cnt + 1;
            chk("frame_done_with_last", 144'(win_valid && exp_q.size() > 0 && exp_q[0].last), 144'(1));
            chk("frame_done_single", 144'(prev_done), 144'(0));
         end
         if (win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL win_unexpected actual=%0h required=no_window", win_data);
            end else begin
               e = exp_q.pop_front();
               chk("win_data", win_data, e.data);
               if (lat_en) chk("win_latency", 144'(cyc), 144'(e.cyc + 2));
               if (win_cnt == 0) first_win = win_data;
               if (win_cnt == (W-2)*(H-2)) frame2_win = win_data;
               last_win = win_data;
               win_cnt++;
            end
         end
         if (lb_wr_en_I) begin
            if (wr_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL wr_unexpected actual=addr%0d required=no_write", lb_wr_addr);
            end else begin
               w = wr_q.pop_front();
               chk("wr_addr", 144'(lb_wr_addr), 144'(w.c));
               chk("wr_data_I", 144'(lb_wr_data_I), 144'(w.v));
               if (w.r >= 1) chk("wr_data_II", 144'(lb_wr_data_II), 144'(img[w.r-1][w.c]));
               if (w.r == 2 && w.c == 5) begin
                  cap_seen = 1'b1;
                  cap_addr = lb_wr_addr;
                  cap_d1   = lb_wr_data_I;
                  cap_d2   = lb_wr_data_II;
               end
            end
         end
         if (in_valid && in_ready) begin
            img[mr][mc] = in_data;
            w.r = mr; w.c = mc; w.v = in_data;
            wr_q.push_back(w);
            if (mr >= 2 && mc >= 2) begin
               e.data = '0;
               for (int r = 0; r < 3; r++)
                  for (int c = 0; c < 3; c++)
                     e.data[(3*r+c)*DW +: DW] = img[mr-2+r][mc-2+c];
               e.last = (mr == H-1) && (mc == W-1);
               e.cyc  = cyc;
               exp_q.push_back(e);
            end
            mc++;
            if (mc == W) begin
               mc = 0;
               mr = (mr == H-1) ? 0 : mr + 1;
            end
         end
      end
      prev_stall    = win_valid && !win_ready;
      prev_win_data = win_data;
      prev_done     = frame_done && !rst;
   end

   // ---------------- stimulus ----------------
   task automatic send_pixel(input logic [DW-1:0] v);
      int n = 0;
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_data  = v;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!acc && n > 1000) begin
            $display("FAIL accept_timeout actual=no_accept required=accept_within_1000");
            $fatal(1, "input stalled");
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int npix, input int gap_at);
      for (int i = 0; i < npix; i++) begin
         if (i == gap_at) repeat (5) @(posedge clk);
         if (i == gap_at) #1;
         send_pixel(DW'((i / W) * W + (i % W)));
      end
   endtask

   task automatic drain();
      bp_en = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("queue_empty", 144'(exp_q.size()), 144'(0));
   endtask

   task automatic clear_stats();
      win_cnt  = 0;
      done_cnt = 0;
      done_at  = 0;
      cap_seen = 1'b0;
   endtask

   task automatic check_frame(input string tag, input int nwin, input int ndone);
      logic [9*DW-1:0] w0;
      int w0_vals[9] = '{0, 1, 2, 30, 31, 32, 60, 61, 62};
      w0 = '0;
      for (int k = 0; k < 9; k++) w0[k*DW +: DW] = DW'(w0_vals[k]);
      chk({tag, "_win_count"}, 144'(win_cnt), 144'(nwin));
      chk({tag, "_done_count"}, 144'(done_cnt), 144'(ndone));
      chk({tag, "_first_win"}, first_win, w0);
      // last window spans rows 27..29, cols 27..29
      chk({tag, "_last_br"}, 144'(last_win[8*DW +: DW]), 144'(899));
      chk({tag, "_last_centre"}, 144'(last_win[4*DW +: DW]), 144'(868));
      chk({tag, "_done_at"}, 144'(done_at), 144'(nwin));
      if (ndone == 2) chk({tag, "_frame2_first"}, frame2_win, w0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 144'(in_ready), 144'(0));
      chk("reset_win_valid", 144'(win_valid), 144'(0));
      chk("reset_frame_done", 144'(frame_done), 144'(0));
      chk("reset_wr_en_II", 144'(lb_wr_en_II), 144'(0));
      chk("reset_win_data", win_data, 144'(0));
      chk("reset_rd_addr", 144'(lb_rd_addr), 144'(0));
      chk("reset_wr_addr", 144'(lb_wr_addr), 144'(0));
      chk("reset_wr_data_I", 144'(lb_wr_data_I), 144'(0));
      chk("reset_wr_data_II", 144'(lb_wr_data_II), 144'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // streaming frame, window always accepted
      clear_stats();
      lat_en = 1'b1;
      send_frame(W*H, -1);
      drain();
      lat_en = 1'b0;
      check_frame("stream", 784, 1);
      chk("wrpath_seen", 144'(cap_seen), 144'(1));
      chk("wrpath_addr", 144'(cap_addr), 144'(5));
      chk("wrpath_data_I", 144'(cap_d1), 144'(65));
      chk("wrpath_data_II", 144'(cap_d2), 144'(35));

      // random backpressure
      clear_stats();
      bp_en = 1'b1;
      send_frame(W*H, -1);
      drain();
      check_frame("backpressure", 784, 1);

      // input gap mid-row
      clear_stats();
      send_frame(W*H, 45);
      drain();
      check_frame("gap", 784, 1);

      // two frames back to back
      clear_stats();
      lat_en = 1'b1;
      send_frame(W*H, -1);
      send_frame(W*H, -1);
      drain();
      lat_en = 1'b0;
      check_frame("b2b", 1568, 2);

      // reset mid-frame, then a fresh frame over stale line buffers
      send_frame(100, -1);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset_no_win", 144'(win_cnt), 144'(0));
      lat_en = 1'b1;
      send_frame(W*H, -1);
      drain();
      lat_en = 1'b0;
      check_frame("after_reset", 784, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
